// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, status bit indices and multiply FSM states
package cpu_pkg;

  localparam logic [5:0] OP_MUL = 6'b100001;
  localparam logic [5:0] OP_MLS = 6'b100010;

  localparam int SR_Z = 0;
  localparam int SR_N = 1;
  localparam int SR_C = 2;
  localparam int SR_T = 3;
  localparam int SR_V = 4;
  localparam int SR_S = 5;
  localparam int SR_I = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    FIX   = 3'd2,
    WR_HI = 3'd3,
    WR_LO = 3'd4
  } mul_state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// rtl/mul_sequencer_if.sv - decode/writeback bundle between the pipeline and the multiply sequencer
interface mul_sequencer_if #(
  parameter int WIDTH = 16
) ();

  logic             start;
  logic [5:0]       encoded_opcode;
  logic [WIDTH-1:0] rs1data;
  logic [WIDTH-1:0] rs2data;
  logic [2:0]       reg_write_addr;
  logic [7:0]       statusregin;
  logic             flush;
  logic             busy;
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             status_we;
  logic [7:0]       statusregout;
  logic             done;

  modport master (
    output start, encoded_opcode, rs1data, rs2data, reg_write_addr, statusregin, flush,
    input  busy, wr_en, wr_addr, wr_data, status_we, statusregout, done
  );

  modport slave (
    input  start, encoded_opcode, rs1data, rs2data, reg_write_addr, statusregin, flush,
    output busy, wr_en, wr_addr, wr_data, status_we, statusregout, done
  );

endinterface

// File: rtl/mul_shift_add_dp.sv
// rtl/mul_shift_add_dp.sv - shift-add multiplier datapath: operand/accumulator registers,
// 17-bit adder, right shifter and two's-complement fix-up of the product.
module mul_shift_add_dp #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_fix,
  input  logic               i_sgn,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_product
);

  localparam logic [WIDTH-1:0]   ONE_W = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_P = (2*WIDTH)'(1);

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_neg;

  // Signed operands become magnitudes; 16'h8000 maps to 32768, which still fits unsigned.
  assign w_a_mag  = (i_sgn && i_a[WIDTH-1]) ? (~i_a + ONE_W) : i_a;
  assign w_b_mag  = (i_sgn && i_b[WIDTH-1]) ? (~i_b + ONE_W) : i_b;
  assign w_addend = r_b[0] ? r_a : '0;
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};
  assign w_neg    = ~{r_acc, r_b} + ONE_P;

  assign o_product = {r_acc, r_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (i_load) begin
      r_a   <= w_a_mag;
      r_b   <= w_b_mag;
      r_acc <= '0;
    end else if (i_step) begin
      // {carry, acc, B} shifted right by one: carry lands in acc MSB, acc LSB in B MSB.
      r_acc <= w_sum[WIDTH:1];
      r_b   <= {w_sum[0], r_b[WIDTH-1:1]};
    end else if (i_fix) begin
      {r_acc, r_b} <= w_neg;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - multi-cycle MUL/MLS controller: stalls the pipeline, runs the
// shift-add datapath, then writes the product high/low halves and the status register.
module mul_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic               clk,
  input logic               rst_n,
  mul_sequencer_if.slave    bus
);

  mul_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_dest;
  logic               r_sgn;
  logic               r_neg_res;

  logic               w_valid_op;
  logic               w_accept;
  logic               w_step;
  logic               w_fix;
  logic [2*WIDTH-1:0] w_product;
  logic               w_hi;
  logic               w_lo;
  logic               w_n;
  logic [7:0]         w_status;

  assign w_valid_op = (bus.encoded_opcode == OP_MUL) || (bus.encoded_opcode == OP_MLS);
  assign w_accept   = (r_state == IDLE) && bus.start && w_valid_op && !bus.flush;
  assign w_step     = (r_state == CALC) && !bus.flush;
  assign w_fix      = (r_state == FIX) && r_neg_res && !bus.flush;

  mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept),
    .i_step    (w_step),
    .i_fix     (w_fix),
    .i_sgn     (bus.encoded_opcode == OP_MLS),
    .i_a       (bus.rs1data),
    .i_b       (bus.rs2data),
    .o_product (w_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dest    <= '0;
      r_sgn     <= 1'b0;
      r_neg_res <= 1'b0;
    end else if (bus.flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dest    <= bus.reg_write_addr;
            r_sgn     <= (bus.encoded_opcode == OP_MLS);
            r_neg_res <= (bus.encoded_opcode == OP_MLS) &&
                         (bus.rs1data[WIDTH-1] ^ bus.rs2data[WIDTH-1]);
            r_cnt     <= '0;
            r_state   <= CALC;
          end
        end
        CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            r_state <= r_sgn ? FIX : WR_HI;
          end
        end
        FIX:     r_state <= WR_HI;
        WR_HI:   r_state <= WR_LO;
        WR_LO:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // A flush seen during a write cycle must kill that cycle's strobes, hence the gating.
  assign w_hi = (r_state == WR_HI) && !bus.flush;
  assign w_lo = (r_state == WR_LO) && !bus.flush;
  assign w_n  = r_sgn && w_product[2*WIDTH-1];

  always_comb begin
    w_status       = bus.statusregin & ((8'h1 << SR_T) | 8'h40 | (8'h1 << SR_I));
    w_status[SR_Z] = (w_product == '0);
    w_status[SR_N] = w_n;
    w_status[SR_C] = 1'b0;
    w_status[SR_V] = 1'b0;
    w_status[SR_S] = w_n;
  end

  assign bus.busy         = (r_state != IDLE);
  assign bus.wr_en        = w_hi || w_lo;
  assign bus.wr_addr      = w_hi ? r_dest : (w_lo ? (r_dest + 3'd1) : 3'd0);
  assign bus.wr_data      = w_hi ? w_product[2*WIDTH-1:WIDTH] :
                            (w_lo ? w_product[WIDTH-1:0] : '0);
  assign bus.status_we    = w_lo;
  assign bus.done         = w_lo;
  assign bus.statusregout = w_lo ? w_status : 8'h00;

endmodule
